// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache geometry constants and miss-handler state encoding
package cache_pkg;

    localparam int WORDS_PER_BLOCK = 8;
    localparam int OFFSET_BITS     = 3;
    localparam int INDEX_BITS      = 6;
    // 16-bit byte address = tag | index | word offset | byte-in-word
    localparam int TAG_BITS        = 16 - INDEX_BITS - OFFSET_BITS - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        WAIT = 2'd2
    } fill_state_t;

endpackage

// File: rtl/fill_word_counter.sv
// rtl/fill_word_counter.sv - wrapping word counter with load, increment and terminal flag
//   clk, rst        : clock, asynchronous active-high reset
//   load/load_value : load a start value (takes priority over inc)
//   inc             : advance by one, wrapping modulo 2**WIDTH
//   last_value      : value at which terminal is flagged
//   count, terminal : current value, count == last_value
module fill_word_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             inc,
    input  logic [WIDTH-1:0] last_value,
    output logic [WIDTH-1:0] count,
    output logic             terminal
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (inc) begin
            count <= count + WIDTH'(1);
        end
    end

    assign terminal = (count == last_value);

endmodule

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache line fill handler: issues 8 word reads, streams returns into the data array
//   clk, rst              : clock, asynchronous active-high reset
//   miss_detected         : miss this cycle, sampled only when idle
//   miss_address          : byte address of the missing access
//   memory_data_valid     : memory_data carries one returned word
//   memory_data           : returned word, in request order
//   fsm_busy              : fill in progress, stall pipeline
//   mem_enable            : read request this cycle at memory_address
//   memory_address        : word-aligned request address
//   write_data_array      : write fill_data into word fill_word_index
//   fill_word_index       : word offset being written
//   fill_data             : combinational copy of memory_data
//   write_tag_array       : one-cycle pulse, install tag and set valid
//   critical_word_valid   : first word of the fill written (CACHE_FILL_CRITICAL_WORD_FIRST_EN only)
// Build option CACHE_FILL_CRITICAL_WORD_FIRST_EN: start the fill at the missing word and wrap.
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH      = 16,
    parameter int WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK,
    parameter int OFFSET_BITS     = cache_pkg::OFFSET_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   miss_detected,
    input  logic [ADDR_WIDTH-1:0]  miss_address,
    input  logic                   memory_data_valid,
    input  logic [15:0]            memory_data,
    output logic                   fsm_busy,
    output logic                   mem_enable,
    output logic [ADDR_WIDTH-1:0]  memory_address,
    output logic                   write_data_array,
    output logic [OFFSET_BITS-1:0] fill_word_index,
    output logic [15:0]            fill_data,
    output logic                   write_tag_array
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    ,
    output logic                   critical_word_valid
`endif
);

    localparam int BASE_BITS = ADDR_WIDTH - OFFSET_BITS - 1;
    localparam logic [OFFSET_BITS-1:0] LAST_WORD = OFFSET_BITS'(WORDS_PER_BLOCK - 1);

    fill_state_t state, state_next;
    logic [BASE_BITS-1:0]   base_q;
    logic [OFFSET_BITS-1:0] issue_cnt, recv_cnt, start_word, issue_last;
    logic issue_term, start_fill, accept, line_done;
    logic unused_addr_bits;

    assign start_fill = (state == IDLE) && miss_detected;
    // returns are only meaningful while a fill owns the memory port
    assign accept     = memory_data_valid && (state != IDLE);
    assign unused_addr_bits = ^miss_address[OFFSET_BITS:0];

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    logic [OFFSET_BITS-1:0] crit_q, done_cnt;
    logic done_term, unused_recv_term;

    assign start_word = miss_address[OFFSET_BITS:1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crit_q <= '0;
        end else if (start_fill) begin
            crit_q <= start_word;
        end
    end

    // issue order wraps, so the last request is the word just before the critical one
    assign issue_last = crit_q - OFFSET_BITS'(1);
    // recv_cnt no longer ends at a fixed value; a plain count of returns decides completion
    assign line_done  = accept && done_term;
    assign critical_word_valid = accept && (done_cnt == '0);

    fill_word_counter #(.WIDTH(OFFSET_BITS)) u_done_cnt (
        .clk(clk), .rst(rst), .load(start_fill), .load_value('0),
        .inc(accept), .last_value(LAST_WORD), .count(done_cnt), .terminal(done_term)
    );

    fill_word_counter #(.WIDTH(OFFSET_BITS)) u_recv_cnt (
        .clk(clk), .rst(rst), .load(start_fill), .load_value(start_word),
        .inc(accept), .last_value(issue_last), .count(recv_cnt), .terminal(unused_recv_term)
    );
`else
    logic recv_term;

    assign start_word = '0;
    assign issue_last = LAST_WORD;
    assign line_done  = accept && recv_term;

    fill_word_counter #(.WIDTH(OFFSET_BITS)) u_recv_cnt (
        .clk(clk), .rst(rst), .load(start_fill), .load_value(start_word),
        .inc(accept), .last_value(LAST_WORD), .count(recv_cnt), .terminal(recv_term)
    );
`endif

    fill_word_counter #(.WIDTH(OFFSET_BITS)) u_issue_cnt (
        .clk(clk), .rst(rst), .load(start_fill), .load_value(start_word),
        .inc(state == FILL), .last_value(issue_last), .count(issue_cnt), .terminal(issue_term)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            base_q <= '0;
        end else begin
            state <= state_next;
            if (start_fill) begin
                base_q <= miss_address[ADDR_WIDTH-1:OFFSET_BITS+1];
            end
        end
    end

    always_comb begin
        state_next       = state;
        mem_enable       = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        fill_word_index  = '0;
        write_tag_array  = line_done;
        case (state)
            IDLE: begin
                if (start_fill) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                mem_enable     = 1'b1;
                memory_address = {base_q, issue_cnt, 1'b0};
                if (line_done) begin
                    state_next = IDLE;
                end else if (issue_term) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (line_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (accept) begin
            write_data_array = 1'b1;
            fill_word_index  = recv_cnt;
        end
    end

    assign fsm_busy  = (state != IDLE);
    assign fill_data = memory_data;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - directed scoreboard bench for cache_fill_fsm with a fixed-latency memory model
module tb_cache_fill_fsm;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = '0;
    logic        memory_data_valid = 1'b0;
    logic [15:0] memory_data = 16'hBEEF;
    logic        fsm_busy, mem_enable, write_data_array, write_tag_array;
    logic [15:0] memory_address, fill_data;
    logic [2:0]  fill_word_index;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    logic        critical_word_valid;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fill_end = 0;
    int writes_seen = 0;
    logic busy_model = 1'b0;
    logic first_wr = 1'b0;

    logic [15:0] exp_addr[$];
    logic [2:0]  exp_idx[$];
    logic [15:0] exp_data[$];
    logic [15:0] pend_addr[$];
    int          pend_ready[$];

    cache_fill_fsm dut (
        .clk(clk), .rst(rst),
        .miss_detected(miss_detected), .miss_address(miss_address),
        .memory_data_valid(memory_data_valid), .memory_data(memory_data),
        .fsm_busy(fsm_busy), .mem_enable(mem_enable), .memory_address(memory_address),
        .write_data_array(write_data_array), .fill_word_index(fill_word_index),
        .fill_data(fill_data), .write_tag_array(write_tag_array)
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
        , .critical_word_valid(critical_word_valid)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mdata(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    function automatic logic [2:0] start_of(input logic [15:0] a);
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
        return a[3:1];
`else
        return 3'd0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_fill(input logic [15:0] a);
        logic [2:0]  w;
        logic [15:0] ad;
        for (int k = 0; k < 8; k++) begin
            w  = start_of(a) + 3'(k);
            ad = {a[15:4], w, 1'b0};
            exp_addr.push_back(ad);
            exp_idx.push_back(w);
            exp_data.push_back(mdata(ad));
        end
    endtask

    task automatic check_outputs_clear(input string tag);
        check({tag, "_busy"}, fsm_busy, 0);
        check({tag, "_mem_en"}, mem_enable, 0);
        check({tag, "_addr"}, memory_address, 0);
        check({tag, "_wr_data"}, write_data_array, 0);
        check({tag, "_index"}, fill_word_index, 0);
        check({tag, "_wr_tag"}, write_tag_array, 0);
    endtask

    task automatic run_cycle(input logic miss, input logic [15:0] addr, input logic stray);
        @(posedge clk);
        #1;
        cyc++;
        miss_detected     = miss;
        miss_address      = addr;
        memory_data_valid = 1'b0;
        memory_data       = 16'h0000;
        if (pend_ready.size() > 0 && pend_ready[0] == cyc) begin
            memory_data_valid = 1'b1;
            memory_data       = mdata(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_ready.pop_front());
        end
        if (stray) begin
            memory_data_valid = 1'b1;
            memory_data       = 16'h7777;
        end
        @(negedge clk);
        check("busy", fsm_busy, busy_model);
        check("wr_tag", write_tag_array, busy_model && (cyc == fill_end));
        check("fill_data", fill_data, memory_data);
        if (mem_enable) begin
            if (exp_addr.size() == 0) check("extra_req", 1, 0);
            else check("req_addr", memory_address, exp_addr.pop_front());
            pend_addr.push_back(memory_address);
            pend_ready.push_back(cyc + LAT);
        end
        if (write_data_array) begin
            writes_seen++;
            if (exp_idx.size() == 0) begin
                check("extra_write", 1, 0);
            end else begin
                check("wr_index", fill_word_index, exp_idx.pop_front());
                check("wr_data", fill_data, exp_data.pop_front());
            end
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
            check("crit_valid", critical_word_valid, first_wr);
`endif
            first_wr = 1'b0;
        end
        if (stray) check("stray_write", write_data_array, 0);
        if (!busy_model && miss) begin
            busy_model  = 1'b1;
            fill_end    = cyc + 8 + LAT;
            first_wr    = 1'b1;
            writes_seen = 0;
            push_fill(addr);
        end else if (busy_model && cyc == fill_end) begin
            busy_model = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) run_cycle(1'b0, 16'h0000, 1'b0);
    endtask

    task automatic drained(input string tag);
        check({tag, "_reqs_left"}, exp_addr.size(), 0);
        check({tag, "_writes_left"}, exp_idx.size(), 0);
    endtask

    initial begin
        #3;
        check_outputs_clear("reset");
        check("reset_fill_data", fill_data, 16'hBEEF);
        @(posedge clk);
        #2;
        rst = 1'b0;

        run_cycle(1'b1, 16'h1234, 1'b0);
        idle(13);
        drained("basic");

        run_cycle(1'b1, 16'h0010, 1'b0);
        idle(12);
        run_cycle(1'b1, 16'hFFF0, 1'b0);
        idle(13);
        drained("b2b");

        run_cycle(1'b1, 16'h0040, 1'b0);
        idle(2);
        repeat (4) run_cycle(1'b1, 16'h8000, 1'b0);
        idle(8);
        drained("busy_miss");

        run_cycle(1'b0, 16'h0000, 1'b1);
        idle(1);
        run_cycle(1'b1, 16'h0100, 1'b0);
        idle(13);
        drained("stray");

        run_cycle(1'b1, 16'h3000, 1'b0);
        for (int i = 0; i < 20 && writes_seen < 3; i++) idle(1);
        check("third_word_seen", writes_seen, 3);
        rst = 1'b1;
        #1;
        check_outputs_clear("mid_rst");
        exp_addr.delete();
        exp_idx.delete();
        exp_data.delete();
        pend_addr.delete();
        pend_ready.delete();
        busy_model = 1'b0;
        first_wr   = 1'b0;
        memory_data_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        idle(15);
        run_cycle(1'b1, 16'h4560, 1'b0);
        idle(13);
        drained("after_rst");

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
        run_cycle(1'b1, 16'h200A, 1'b0);
        idle(13);
        drained("crit");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss handler between the L1 cache arrays and the multi-cycle main memory (memory4c-style, valid-returning).
- When the cache reports a miss, the block fetches the whole 16-byte line (8 x 16-bit words) from memory and streams each word into the data array.
- It writes the tag array once the line is complete, and holds the pipeline via fsm_busy for the whole fill.

Parameters:
- ADDR_WIDTH, 16, byte address width; bit 0 always 0 on memory requests.
- WORDS_PER_BLOCK, 8, words per cache line; must be a power of 2.
- OFFSET_BITS, 3, log2(WORDS_PER_BLOCK).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- miss_detected  in  1  cache miss this cycle; level, sampled only in IDLE
- miss_address  in  ADDR_WIDTH  byte address of the missing access
- memory_data_valid  in  1  memory_data holds one returned word this cycle
- memory_data  in  16  returned word, in request order
- fsm_busy  out  1  fill in progress; stall pipeline
- mem_enable  out  1  issue read request to memory this cycle
- memory_address  out  ADDR_WIDTH  word-aligned request address
- write_data_array  out  1  write fill_data into word fill_word_index of the victim line
- fill_word_index  out  OFFSET_BITS  word offset being written
- fill_data  out  16  combinational copy of memory_data
- write_tag_array  out  1  one-cycle pulse: install tag and set valid

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; all counters=0; latched base=0.
  - Every output is 0 except fill_data, which follows memory_data.
- States: IDLE, FILL, WAIT.
- IDLE:
  - If miss_detected=1, latch base = miss_address[ADDR_WIDTH-1:OFFSET_BITS+1] and move to FILL.
  - fsm_busy stays 0 during the miss cycle and rises on the next edge.
  - memory_data_valid is ignored in IDLE.
- FILL (issue phase):
  - mem_enable=1 every cycle.
  - memory_address = {base, issue_cnt, 1'b0}.
  - issue_cnt increments each cycle.
  - After request WORDS_PER_BLOCK-1 is issued, go to WAIT.
  - Exactly 8 requests are issued, on consecutive cycles.
- Receive path (active in both FILL and WAIT):
  - Each memory_data_valid=1 asserts write_data_array=1 with fill_word_index=recv_cnt (combinational, same cycle); recv_cnt increments.
  - Valid may arrive while issuing is still in progress.
- Completion:
  - Asserted on the cycle the 8th valid is accepted (recv_cnt==WORDS_PER_BLOCK-1 with valid=1).
  - write_tag_array=1 and write_data_array=1 in the same cycle.
  - Next state is IDLE; fsm_busy falls on that edge.
- fsm_busy = (state != IDLE).
- Ordering: memory returns words in request order. A 9th valid cannot occur while busy; any valid seen in IDLE is dropped.
- miss_detected while busy is ignored. The cache re-raises it after the fill, then hits.
- Counter arithmetic: all counters are OFFSET_BITS wide and wrap modulo WORDS_PER_BLOCK. Line base never changes during a fill.
- Reset mid-fill: immediate return to IDLE and outputs cleared. No tag write occurs, so a partial line stays invalid.
- Latency: with memory latency L cycles from request to valid, the fill takes 8+L cycles from the miss cycle to the write_tag_array pulse.

Optional Feature:
- Macro: CACHE_FILL_CRITICAL_WORD_FIRST_EN.
- Defined:
  - Also latch crit = miss_address[OFFSET_BITS:1].
  - issue_cnt and recv_cnt start at crit and wrap modulo 8 (e.g. crit=5 gives order 5,6,7,0,1,2,3,4).
  - Completion is counted by a separate 3-bit done counter reaching 7, not by recv_cnt value.
  - Additional output critical_word_valid (1 bit) pulses with the first write_data_array of the fill, so the pipeline can restart early.
- Undefined: fills always start at word 0; no critical_word_valid port.

Decomposition:
- Shared package cache_pkg holds:
  - state encodings IDLE/FILL/WAIT (2 bits);
  - constants WORDS_PER_BLOCK=8, OFFSET_BITS=3, TAG_BITS, INDEX_BITS, so the cache and data/tag arrays agree.
- One sub-module, fill_word_counter: a 3-bit wrapping counter with load, increment and terminal flag, instantiated twice (issue, receive). In the critical-word-first build it is instantiated three times, adding the done counter.

Test Plan:
- Basic fill: reset, miss_address=0x1234, memory latency 4:
  - requests at 0x1230,0x1232,...,0x123E on 8 consecutive cycles;
  - 8 write_data_array pulses with index 0..7;
  - write_tag_array on cycle 12 after the miss;
  - fsm_busy high cycles 1..12.
- Back-to-back: miss 0x0010, then miss 0xFFF0 the cycle after completion:
  - second fill addresses 0xFFF0..0xFFFE;
  - no address leak from the first fill.
- Miss while busy: raise miss_detected=1, addr 0x8000, mid-fill of 0x0040:
  - base stays 0x0040;
  - exactly 8 requests issued.
- Stray valid: memory_data_valid=1 in IDLE:
  - write_data_array=0, write_tag_array=0;
  - recv_cnt unchanged.
- Reset mid-fill: assert rst after the 3rd returned word:
  - all outputs 0 asynchronously, before the next clk;
  - no write_tag_array;
  - a later miss fills normally from word 0.
- CACHE_FILL_CRITICAL_WORD_FIRST_EN: miss_address=0x200A:
  - requests 0x200A,0x200C,0x200E,0x2000..0x2008;
  - critical_word_valid with index 5;
  - write_tag_array on the 8th valid.
